// File: rtl/apb_completer_regfile.sv
// apb_completer_regfile: APB4 completer with REG_NUM byte-writable registers,
// programmable wait states and PSLVERR on illegal accesses.
// Register 0 drives ctrl_out; register REG_NUM-1 is read-only and mirrors status_in.
// Optional feature macro: APB_CMPL_PROT_EN (unprivileged writes to register 0 error out).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no transfer; waiting for a setup phase (PSEL=1, PENABLE=0)
// S_ACCESS | transfer latched; counting wait states, PREADY when cnt==0
module apb_completer_regfile #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned STROBE_WIDTH = 4,
    parameter int unsigned REG_NUM      = 8,
    parameter int unsigned WAIT_STATES  = 1,
    parameter int unsigned BASE_ADDR    = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [STROBE_WIDTH-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [DATA_WIDTH-1:0]   ctrl_out,
    input  logic [DATA_WIDTH-1:0]   status_in
);

    localparam int unsigned IDX_W = (REG_NUM > 2) ? $clog2(REG_NUM) : 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [3:0]              r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STROBE_WIDTH-1:0] r_strb;
    logic [2:0]              r_prot;
    logic [DATA_WIDTH-1:0]   r_regs [REG_NUM-1];

    logic                    w_setup;
    logic                    w_abort;
    logic                    w_done;
    logic                    w_ready;
    logic                    w_borrow;
    logic [ADDR_WIDTH-1:0]   w_off;
    logic [ADDR_WIDTH-3:0]   w_word;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_in_range;
    logic                    w_last;
    logic                    w_err;
    logic                    w_wr_en;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_unused;

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; an access-phase drop of PSEL/PENABLE aborts without writing
    always_comb begin
        w_next_state = r_state;
        w_setup      = 1'b0;
        w_abort      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_setup      = 1'b1;
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!(PSEL && PENABLE)) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Latch the setup-phase transfer attributes and run the wait-state down-counter
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_prot  <= '0;
        end else if (w_setup) begin
            r_cnt   <= 4'(WAIT_STATES);
            r_addr  <= PADDR;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            r_strb  <= PSTRB;
            r_prot  <= PPROT;
        end else if (w_abort) begin
            r_cnt   <= '0;
        end else if ((r_state == S_ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // Address decode works only from latched flops so PREADY/PSLVERR have no bus-input path
    assign {w_borrow, w_off} = {1'b0, r_addr} - {1'b0, ADDR_WIDTH'(BASE_ADDR)};
    assign w_word     = w_off[ADDR_WIDTH-1:2];
    assign w_idx      = w_word[IDX_W-1:0];
    assign w_in_range = !w_borrow && (w_word < (ADDR_WIDTH-2)'(REG_NUM));
    assign w_last     = (w_idx == IDX_W'(REG_NUM - 1));

`ifdef APB_CMPL_PROT_EN
    assign w_err = (w_off[1:0] != 2'b00) || !w_in_range || (r_write && w_last)
                 || (r_write && (w_idx == '0) && !r_prot[0]);
    assign w_unused = ^r_prot[2:1];
`else
    assign w_err = (w_off[1:0] != 2'b00) || !w_in_range || (r_write && w_last);
    assign w_unused = ^r_prot;
`endif

    assign w_ready = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    assign w_wr_en = w_done && r_write && !w_err;

    // Register file: byte-lane writes on the committing edge
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < int'(REG_NUM) - 1; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            for (int i = 0; i < int'(REG_NUM) - 1; i++) begin
                if (w_idx == IDX_W'(i)) begin
                    for (int b = 0; b < int'(STROBE_WIDTH); b++) begin
                        if (r_strb[b]) begin
                            r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read mux; the last index returns the live status input
    always_comb begin
        w_rdata = '0;
        if (w_last) begin
            w_rdata = status_in;
        end else begin
            for (int i = 0; i < int'(REG_NUM) - 1; i++) begin
                if (w_idx == IDX_W'(i)) begin
                    w_rdata = r_regs[i];
                end
            end
        end
    end

    assign PREADY   = w_ready;
    assign PSLVERR  = w_ready && w_err;
    assign PRDATA   = (w_ready && !r_write && !w_err) ? w_rdata : '0;
    assign ctrl_out = r_regs[0];

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Directed bench for apb_completer_regfile: three instances with WAIT_STATES 1, 0 and 3
// share the bus wires; each has its own PSEL bit.
module tb_apb_completer_regfile;

    logic        pclk;
    logic        presetn;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] status_in;

    logic [31:0] prdata0, prdata1, prdata2;
    logic [31:0] ctrl0, ctrl1, ctrl2;
    logic [2:0]  pready;
    logic [2:0]  pslverr;

    int n_checks;
    int n_pass;

    apb_completer_regfile #(.WAIT_STATES(1)) u_ws1 (
        .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata0), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
        .ctrl_out(ctrl0), .status_in(status_in)
    );

    apb_completer_regfile #(.WAIT_STATES(0)) u_ws0 (
        .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata1), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
        .ctrl_out(ctrl1), .status_in(status_in)
    );

    apb_completer_regfile #(.WAIT_STATES(3)) u_ws3 (
        .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[2]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata2), .PREADY(pready[2]), .PSLVERR(pslverr[2]),
        .ctrl_out(ctrl2), .status_in(status_in)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic logic [31:0] rd_of(input int d);
        case (d)
            0:       return prdata0;
            1:       return prdata1;
            default: return prdata2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic bus_idle();
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        pstrb   = 4'h0;
    endtask

    // Full transfer on instance d; returns at #1 after the completing edge with the bus still driven
    task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr,
                        output logic [31:0] rd, output logic err, output int cyc);
        logic got;
        psel    = 3'b000;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrb   = st;
        pprot   = pr;
        rd      = '0;
        err     = 1'b1;
        got     = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc     = 1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge pclk);
            cyc++;
            if (pready[d]) begin
                got = 1'b1;
                rd  = rd_of(d);
                err = pslverr[d];
            end
            @(posedge pclk); #1;
        end
        if (!got) chk("pready_timeout", {31'd0, got}, 32'd1);
    endtask

    logic [31:0] rd;
    logic        err;
    int          cyc;

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        presetn   = 1'b0;
        status_in = 32'hA5A5_0001;
        paddr     = 32'h0;
        pwdata    = 32'h0;
        pprot     = 3'b000;
        bus_idle();

        // Reset held while the bus toggles
        for (int i = 0; i < 4; i++) begin
            @(posedge pclk); #1;
            psel    = 3'b111;
            pwrite  = i[0];
            paddr   = 32'h0;
            pwdata  = 32'hFFFF_FFFF;
            pstrb   = 4'hF;
            penable = i[1];
        end
        @(negedge pclk);
        chk("rst_pready",  {29'd0, pready},  32'd0);
        chk("rst_pslverr", {29'd0, pslverr}, 32'd0);
        chk("rst_prdata",  prdata0, 32'd0);
        chk("rst_ctrl",    ctrl0,   32'd0);
        @(posedge pclk); #1;
        bus_idle();
        presetn = 1'b1;
        @(posedge pclk); #1;

        // Reset asserted mid-ACCESS drops the write
        psel[0] = 1'b1; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h1234_5678; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        chk("midrst_pready", {31'd0, pready[0]}, 32'd0);
        presetn = 1'b0;
        #2;
        bus_idle();
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 3'b000, rd, err, cyc);
        chk("midrst_reg1", rd, 32'h0);

        // Strobed write, one wait state
        xfer(0, 1'b1, 32'h0, 32'h0000_03E8, 4'b0010, 3'b001, rd, err, cyc);
        chk("wr0_cycles", cyc, 32'd3);
        chk("wr0_err", {31'd0, err}, 32'd0);
        chk("wr0_ctrl", ctrl0, 32'h0000_0300);

        // Readback of register 0 and the status mirror
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, err, cyc);
        chk("rd0_data", rd, 32'h0000_0300);
        chk("rd0_err", {31'd0, err}, 32'd0);
        xfer(0, 1'b0, 32'h1C, 32'h0, 4'hF, 3'b000, rd, err, cyc);
        chk("rd_status", rd, 32'hA5A5_0001);

        // Error cases
        xfer(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 3'b001, rd, err, cyc);
        chk("err_idx8", {31'd0, err}, 32'd1);
        chk("err_idx8_ctrl", ctrl0, 32'h0000_0300);
        xfer(0, 1'b1, 32'h02, 32'hFFFF_FFFF, 4'hF, 3'b001, rd, err, cyc);
        chk("err_unaligned", {31'd0, err}, 32'd1);
        chk("err_unaligned_ctrl", ctrl0, 32'h0000_0300);
        xfer(0, 1'b1, 32'h1C, 32'h0000_0000, 4'hF, 3'b001, rd, err, cyc);
        chk("err_ro", {31'd0, err}, 32'd1);
        xfer(0, 1'b0, 32'h1C, 32'h0, 4'h0, 3'b000, rd, err, cyc);
        chk("err_ro_readback", rd, 32'hA5A5_0001);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, rd, err, cyc);
        chk("err_rd_oob", {31'd0, err}, 32'd1);
        chk("err_rd_oob_data", rd, 32'h0);

        // Byte lanes and zero-strobe no-op on register 1
        xfer(0, 1'b1, 32'h4, 32'hAABB_CCDD, 4'b0101, 3'b001, rd, err, cyc);
        xfer(0, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'b0000, 3'b001, rd, err, cyc);
        chk("strb0_err", {31'd0, err}, 32'd0);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 3'b000, rd, err, cyc);
        chk("lanes_reg1", rd, 32'h00BB_00DD);

        // Zero wait states, back-to-back writes
        xfer(1, 1'b1, 32'h4, 32'h1111_1111, 4'hF, 3'b001, rd, err, cyc);
        chk("b2b_1_cycles", cyc, 32'd2);
        xfer(1, 1'b1, 32'h8, 32'h2222_2222, 4'hF, 3'b001, rd, err, cyc);
        chk("b2b_2_cycles", cyc, 32'd2);
        xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, 3'b000, rd, err, cyc);
        chk("b2b_rd4", rd, 32'h1111_1111);
        xfer(1, 1'b0, 32'h8, 32'h0, 4'h0, 3'b000, rd, err, cyc);
        chk("b2b_rd8", rd, 32'h2222_2222);
        bus_idle();
        @(posedge pclk); #1;

        // Abort: drop PSEL during the wait states of a 3-wait-state completer
        psel[2] = 1'b1; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h0000_0005; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        chk("abort_pready_a", {31'd0, pready[2]}, 32'd0);
        @(posedge pclk); #1;
        @(negedge pclk);
        chk("abort_pready_b", {31'd0, pready[2]}, 32'd0);
        @(posedge pclk); #1;
        bus_idle();
        @(posedge pclk); #1;
        @(negedge pclk);
        chk("abort_pready_c", {31'd0, pready[2]}, 32'd0);
        @(posedge pclk); #1;
        xfer(2, 1'b0, 32'h4, 32'h0, 4'h0, 3'b000, rd, err, cyc);
        chk("abort_nowrite", rd, 32'h0);
        chk("ws3_cycles", cyc, 32'd5);
        xfer(2, 1'b1, 32'h4, 32'h0000_0005, 4'hF, 3'b001, rd, err, cyc);
        xfer(2, 1'b0, 32'h4, 32'h0, 4'h0, 3'b000, rd, err, cyc);
        chk("ws3_rd", rd, 32'h0000_0005);

        // Protection on register 0
        xfer(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, 3'b000, rd, err, cyc);
`ifdef APB_CMPL_PROT_EN
        chk("prot_unpriv_err", {31'd0, err}, 32'd1);
        chk("prot_unpriv_ctrl", ctrl0, 32'h0000_0300);
`else
        chk("prot_unpriv_err", {31'd0, err}, 32'd0);
        chk("prot_unpriv_ctrl", ctrl0, 32'hFFFF_FFFF);
`endif
        xfer(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, 3'b001, rd, err, cyc);
        chk("prot_priv_err", {31'd0, err}, 32'd0);
        chk("prot_priv_ctrl", ctrl0, 32'hFFFF_FFFF);
        chk("other_ctrl", ctrl1, 32'h0);
        chk("other_ctrl3", ctrl2, 32'h0);
        bus_idle();
        @(posedge pclk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
